// File: rtl/shift_issue_ctrl_if.sv
// Bus bundle for shift_issue_ctrl.
// Carries three groups of signals:
//   req_*  : the execute-stage request port (valid/ready).
//   sh_*   : the start/done port to the multi-cycle shifter.
//   resp_* : the response port (valid/ready).
// The slave modport is the controller's view. The master modport is the
// surrounding pipeline and shifter view, and is the one a bench drives.
// Handshake rule for both valid/ready ports: a transfer happens on a rising
// edge where valid && ready are both high. A source never withdraws valid, and
// never changes the payload, while valid is high and ready is low.
interface shift_issue_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic        req_funct7_5;
  logic [31:0] req_rs1;
  logic [4:0]  req_shamt;
  logic [4:0]  req_rd;

  logic        sh_start;
  logic [31:0] sh_data_in;
  logic [4:0]  sh_shift_amount;
  logic [1:0]  sh_mode;
  logic [31:0] sh_data_out;
  logic        sh_done;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_err;

  modport slave (
    input  req_valid, req_funct3, req_funct7_5, req_rs1, req_shamt, req_rd,
    output req_ready,
    output sh_start, sh_data_in, sh_shift_amount, sh_mode,
    input  sh_data_out, sh_done,
    output resp_valid, resp_data, resp_rd, resp_err,
    input  resp_ready
  );

  modport master (
    output req_valid, req_funct3, req_funct7_5, req_rs1, req_shamt, req_rd,
    input  req_ready,
    input  sh_start, sh_data_in, sh_shift_amount, sh_mode,
    output sh_data_out, sh_done,
    input  resp_valid, resp_data, resp_rd, resp_err,
    output resp_ready
  );
endinterface

// File: rtl/shift_issue_ctrl.sv
// shift_issue_ctrl
// Queues RISC-V shift requests in an in-order FIFO and decodes funct3/funct7
// into a shifter mode. Each request gets one start pulse to the multi-cycle
// shifter; the controller then waits for done (or a timeout) and returns the
// result with its rd tag.
// Ports:
//   clk, reset : clock; synchronous active-high reset
//   bus        : slave view of shift_issue_ctrl_if (request, shifter, response)
//   busy       : registered; high while the FIFO is non-empty or FSM not IDLE
//   dbg_state  : current FSM state (IDLE=0, ISSUE=1, ARM=2, WAIT=3, RESP=4)
module shift_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  shift_issue_ctrl_if.slave    bus,
  output logic                 busy,
  output logic [2:0]           dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ARM, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] rs1;
    logic [4:0]  shamt;
    logic [4:0]  rd;
  } req_t;

  req_t          mem_q [DEPTH];
  req_t          head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty, push, pop;

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   sh_data_q, sh_data_d;
  logic [4:0]    sh_amt_q, sh_amt_d;
  logic [1:0]    sh_mode_q, sh_mode_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_data_q, resp_data_d;
  logic [4:0]    resp_rd_q, resp_rd_d;
  logic          resp_err_q, resp_err_d;
  logic          busy_q, busy_d;
  logic          head_legal;
  logic [1:0]    head_mode;

  // req_ready depends only on the registered occupancy, never on this cycle's pop.
  assign full          = (count_q == CW'(DEPTH));
  assign empty         = (count_q == '0);
  assign push          = bus.req_valid && !full;
  assign head          = mem_q[rd_ptr_q];
  assign bus.req_ready = !full;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{funct3: bus.req_funct3, funct7_5: bus.req_funct7_5,
                                   rs1: bus.req_rs1, shamt: bus.req_shamt, rd: bus.req_rd};
  end

  always_comb begin
    head_legal = 1'b0;
    head_mode  = 2'b00;
    if (head.funct3 == 3'b001 && !head.funct7_5) begin
      head_legal = 1'b1;
      head_mode  = 2'b00;
    end else if (head.funct3 == 3'b101) begin
      head_legal = 1'b1;
      head_mode  = head.funct7_5 ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    sh_data_d    = sh_data_q;
    sh_amt_d     = sh_amt_q;
    sh_mode_d    = sh_mode_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_rd_d    = resp_rd_q;
    resp_err_d   = resp_err_q;
    pop          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          resp_rd_d = head.rd;
          if (!head_legal) begin
            resp_data_d  = '0;
            resp_err_d   = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = S_RESP;
          end else if (head.shamt == '0) begin
            // Zero shift is the identity; no need to occupy the shifter.
            resp_data_d  = head.rs1;
            resp_err_d   = 1'b0;
            resp_valid_d = 1'b1;
            state_d      = S_RESP;
          end else begin
            sh_data_d = head.rs1;
            sh_amt_d  = head.shamt;
            sh_mode_d = head_mode;
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_ARM;
      end
      // done may still show the previous operation here, so it is not looked at.
      S_ARM: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.sh_done) begin
          resp_data_d  = bus.sh_data_out;
          resp_err_d   = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          resp_data_d  = '0;
          resp_err_d   = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    busy_d   = (state_d != S_IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      tmo_q        <= '0;
      sh_data_q    <= '0;
      sh_amt_q     <= '0;
      sh_mode_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_rd_q    <= '0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      tmo_q        <= tmo_d;
      sh_data_q    <= sh_data_d;
      sh_amt_q     <= sh_amt_d;
      sh_mode_q    <= sh_mode_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_rd_q    <= resp_rd_d;
      resp_err_q   <= resp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.sh_start        = (state_q == S_ISSUE);
  assign bus.sh_data_in      = sh_data_q;
  assign bus.sh_shift_amount = sh_amt_q;
  assign bus.sh_mode         = sh_mode_q;
  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_data       = resp_data_q;
  assign bus.resp_rd         = resp_rd_q;
  assign bus.resp_err        = resp_err_q;
  assign busy                = busy_q;
  assign dbg_state           = state_q;
endmodule

// File: tb/tb_shift_issue_ctrl.sv
module tb_shift_issue_ctrl;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 40;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       busy;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  shift_issue_ctrl_if bus();

  shift_issue_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected responses {err, rd, data}, expected shifter issues
  // {mode, amount, operand}, and per-issue "shifter hangs" flags.
  logic [37:0] exp_q[$];
  logic [38:0] issue_q[$];
  bit          hang_q[$];
  int          start_count = 0;
  bit          rand_rdy = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- shifter model ----------------
  // Result is ready amount+1 cycles after the start edge; done is a level that
  // drops on the next start. A hung operation never raises done.
  logic        mdl_done = 1'b0;
  logic [31:0] mdl_out = '0;
  logic [31:0] mdl_res = '0;
  int          mdl_cnt = 0;
  bit          mdl_hang = 1'b0;
  assign bus.sh_done     = mdl_done;
  assign bus.sh_data_out = mdl_out;

  always @(posedge clk) begin
    if (bus.sh_start) begin
      mdl_cnt  <= int'(bus.sh_shift_amount) + 1;
      mdl_done <= 1'b0;
      mdl_hang <= (hang_q.size() != 0) ? hang_q.pop_front() : 1'b0;
      case (bus.sh_mode)
        2'b00:   mdl_res <= bus.sh_data_in << bus.sh_shift_amount;
        2'b01:   mdl_res <= bus.sh_data_in >> bus.sh_shift_amount;
        default: mdl_res <= $unsigned($signed(bus.sh_data_in) >>> bus.sh_shift_amount);
      endcase
    end else if (mdl_cnt != 0) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1 && !mdl_hang) begin
        mdl_done <= 1'b1;
        mdl_out  <= mdl_res;
      end
    end
  end

  // Random consumer back-pressure for the random phase.
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 bus.resp_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- monitor ----------------
  bit          prev_start = 1'b0;
  bit          stall_prev = 1'b0;
  logic [37:0] stall_val;
  logic [37:0] e_resp;
  logic [38:0] e_iss;

  always @(negedge clk) begin
    if (reset) begin
      prev_start = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (bus.sh_start) begin
        start_count++;
        checks++;
        assert (!prev_start) else begin
          errors++;
          $error("FAIL start_pulse_width: observed start on consecutive cycles, expected single cycle");
        end
        checks++;
        assert (issue_q.size() != 0) else begin
          errors++;
          $error("FAIL start_unexpected: observed start with no issue pending, expected none");
        end
        if (issue_q.size() != 0) begin
          e_iss = issue_q.pop_front();
          chk("issue_mode_amt_data", {bus.sh_mode, bus.sh_shift_amount, bus.sh_data_in}, e_iss);
        end
      end
      prev_start = bus.sh_start;
      if (stall_prev) begin
        chk("resp_hold", {bus.resp_valid, bus.resp_err, bus.resp_rd, bus.resp_data},
            {1'b1, stall_val});
      end
      if (bus.resp_valid && bus.resp_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL resp_unexpected: observed rd=%0d with empty scoreboard", bus.resp_rd);
        end
        if (exp_q.size() != 0) begin
          e_resp = exp_q.pop_front();
          chk("resp_err_rd_data", {bus.resp_err, bus.resp_rd, bus.resp_data}, e_resp);
        end
      end
      stall_prev = bus.resp_valid && !bus.resp_ready;
      stall_val  = {bus.resp_err, bus.resp_rd, bus.resp_data};
    end
  end

  // ---------------- reference model + driver ----------------
  task automatic model_push(input logic [2:0] f3, input logic f7, input logic [31:0] rs1,
                            input logic [4:0] sa, input logic [4:0] rd, input bit hang);
    bit          legal;
    logic [63:0] ext;
    logic [31:0] data;
    logic [1:0]  mode;
    legal = (f3 == 3'b001 && !f7) || (f3 == 3'b101);
    if (!legal) begin
      exp_q.push_back({1'b1, rd, 32'h0});
    end else if (sa == 5'd0) begin
      exp_q.push_back({1'b0, rd, rs1});
    end else begin
      mode = (f3 == 3'b001) ? 2'd0 : (f7 ? 2'd2 : 2'd1);
      issue_q.push_back({mode, sa, rs1});
      hang_q.push_back(hang);
      if (f3 == 3'b001) begin
        data = rs1 << sa;
      end else if (!f7) begin
        data = rs1 >> sa;
      end else begin
        ext  = {{32{rs1[31]}}, rs1};
        ext  = ext >> sa;
        data = ext[31:0];
      end
      if (hang) exp_q.push_back({1'b1, rd, 32'h0});
      else      exp_q.push_back({1'b0, rd, data});
    end
  endtask

  task automatic push_req(input logic [2:0] f3, input logic f7, input logic [31:0] rs1,
                          input logic [4:0] sa, input logic [4:0] rd, input bit hang);
    bit ok = 1'b0;
    bus.req_valid    = 1'b1;
    bus.req_funct3   = f3;
    bus.req_funct7_5 = f7;
    bus.req_rs1      = rs1;
    bus.req_shamt    = sa;
    bus.req_rd       = rd;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        model_push(f3, f7, rs1, sa, rd, hang);
      end
    end
    bus.req_valid = 1'b0;
    chk("push_accepted", ok, 1'b1);
  endtask

  task automatic measure_lat(input string tag, input int exp_lat);
    int lat = -1;
    for (int k = 1; k <= 100 && lat < 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.resp_valid) lat = k;
    end
    chk(tag, lat, exp_lat);
  endtask

  task automatic drain(input string tag, input int max);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, (n < max), 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sh_start"},  bus.sh_start, 1'b0);
    chk({tag, "_sh_data"},   bus.sh_data_in, 32'h0);
    chk({tag, "_sh_amt"},    bus.sh_shift_amount, 5'h0);
    chk({tag, "_sh_mode"},   bus.sh_mode, 2'h0);
    chk({tag, "_resp_v"},    bus.resp_valid, 1'b0);
    chk({tag, "_resp_data"}, bus.resp_data, 32'h0);
    chk({tag, "_resp_rd"},   bus.resp_rd, 5'h0);
    chk({tag, "_resp_err"},  bus.resp_err, 1'b0);
    chk({tag, "_busy"},      busy, 1'b0);
    chk({tag, "_req_ready"}, bus.req_ready, 1'b1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int          s;
    logic [37:0] held;
    int          w;
    logic [2:0]  f3_tab [6];
    f3_tab[0] = 3'b001; f3_tab[1] = 3'b101; f3_tab[2] = 3'b101;
    f3_tab[3] = 3'b010; f3_tab[4] = 3'b001; f3_tab[5] = 3'b111;

    bus.req_valid = 1'b0; bus.req_funct3 = '0; bus.req_funct7_5 = 1'b0;
    bus.req_rs1 = '0; bus.req_shamt = '0; bus.req_rd = '0; bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    // SLL 1 << 4, rd 5: one start, valid 8 cycles after the push edge.
    s = start_count;
    push_req(3'b001, 1'b0, 32'h0000_0001, 5'd4, 5'd5, 1'b0);
    measure_lat("sll_latency", 8);
    drain("sll_drain", 200);
    chk("sll_starts", start_count - s, 1);

    // SRA and SRL of 0x8000_0000 by 31.
    push_req(3'b101, 1'b1, 32'h8000_0000, 5'd31, 5'd7, 1'b0);
    drain("sra_drain", 200);
    push_req(3'b101, 1'b0, 32'h8000_0000, 5'd31, 5'd8, 1'b0);
    drain("srl_drain", 200);

    // Zero-amount bypass: no shifter issue, response one cycle after pop.
    s = start_count;
    push_req(3'b001, 1'b0, 32'hDEAD_BEEF, 5'd0, 5'd9, 1'b0);
    measure_lat("bypass_latency", 1);
    drain("bypass_drain", 200);
    chk("bypass_no_start", start_count - s, 0);

    // Illegal funct3.
    s = start_count;
    push_req(3'b010, 1'b0, 32'h1234_5678, 5'd3, 5'd10, 1'b0);
    measure_lat("illegal_latency", 1);
    drain("illegal_drain", 200);
    chk("illegal_no_start", start_count - s, 0);

    // Fill: one in flight plus DEPTH queued while the consumer stalls.
    bus.resp_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      push_req((i % 2 == 0) ? 3'b001 : 3'b101, 1'b0, 32'h0000_0F00 + 32'(i), 5'(i + 1), 5'(11 + i), 1'b0);
    end
    chk("full_req_ready", bus.req_ready, 1'b0);
    w = 0;
    while (!bus.resp_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("full_first_resp", bus.resp_valid, 1'b1);
    held = {bus.resp_err, bus.resp_rd, bus.resp_data};
    repeat (10) @(negedge clk);
    chk("full_stall_payload", {bus.resp_valid, bus.resp_err, bus.resp_rd, bus.resp_data}, {1'b1, held});
    @(posedge clk);
    #1 bus.resp_ready = 1'b1;
    drain("full_drain", 400);

    // Shifter hangs on the first request; the following one completes normally.
    push_req(3'b001, 1'b0, 32'h0000_0003, 5'd3, 5'd20, 1'b1);
    push_req(3'b101, 1'b0, 32'h0000_00F0, 5'd4, 5'd21, 1'b0);
    drain("timeout_drain", 400);

    // Random traffic with random back-pressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push_req(f3_tab[$urandom_range(0, 5)], 1'($urandom_range(0, 1)), $urandom,
               ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
               5'($urandom_range(0, 31)), 1'b0);
    end
    drain("random_drain", 6000);
    rand_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.resp_ready = 1'b1;

    // Reset while one request is in WAIT and three are queued.
    for (int i = 0; i < 4; i++) begin
      push_req(3'b101, 1'b0, 32'hFFFF_0000, 5'd31, 5'(24 + i), 1'b0);
    end
    chk("midop_busy", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    issue_q.delete();
    hang_q.delete();
    check_reset_outputs("midop_reset");
    reset = 1'b0;
    push_req(3'b001, 1'b0, 32'h0000_0001, 5'd1, 5'd3, 1'b0);
    drain("post_reset_drain", 200);

    chk("scoreboard_empty", exp_q.size(), 0);
    chk("issues_empty", issue_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
